// File: rtl/alu_pkg.sv
// Shared constants and types for the 64-bit execute-stage ALU.
package alu_pkg;

    localparam int DATA_W = 64;
    localparam int OP_W   = 4;

    // Opcode encodings; 1011-1111 are reserved and produce a zero result.
    localparam logic [OP_W-1:0] ADD  = 4'b0000;
    localparam logic [OP_W-1:0] SUB  = 4'b0001;
    localparam logic [OP_W-1:0] AND  = 4'b0010;
    localparam logic [OP_W-1:0] OR   = 4'b0011;
    localparam logic [OP_W-1:0] XOR  = 4'b0100;
    localparam logic [OP_W-1:0] SLL  = 4'b0101;
    localparam logic [OP_W-1:0] SRL  = 4'b0110;
    localparam logic [OP_W-1:0] SRA  = 4'b0111;
    localparam logic [OP_W-1:0] SLT  = 4'b1000;
    localparam logic [OP_W-1:0] SEQ  = 4'b1001;
    localparam logic [OP_W-1:0] SRNE = 4'b1010;

    // Result word plus the three status flags, kept together so the
    // output register is a single assignment.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              carry;
        logic              overflow;
    } alu_res_t;

    // Value the output register takes while reset is asserted.
    localparam alu_res_t RES_RST = '{result: '0, zero: 1'b1, carry: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_64bit_core.sv
// Combinational ALU datapath: one 65-bit adder shared by ADD/SUB/SLT,
// bitwise ops, barrel shifts and compares; produces next result and flags.
module alu_64bit_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output alu_res_t          res
);

    logic              use_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              add_ovf;
    logic [5:0]        shamt;

    // Shared adder: subtraction is A + ~B + 1, so the carry out of bit 64
    // is the inverse of the borrow.
    always_comb begin
        use_sub = (op == SUB) || (op == SLT);
        b_eff   = use_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, use_sub};
        add_ovf = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        shamt   = b[5:0];
    end

    // Operation select; flags other than zero stay low outside ADD/SUB.
    always_comb begin
        res          = '0;
        res.result   = '0;
        res.carry    = 1'b0;
        res.overflow = 1'b0;
        unique case (op)
            ADD: begin
                res.result   = sum[DATA_W-1:0];
                res.carry    = sum[DATA_W];
                res.overflow = add_ovf;
            end
            SUB: begin
                res.result   = sum[DATA_W-1:0];
                res.carry    = ~sum[DATA_W];
                res.overflow = add_ovf;
            end
            AND:  res.result = a & b;
            OR:   res.result = a | b;
            XOR:  res.result = a ^ b;
            SLL:  res.result = a << shamt;
            SRL:  res.result = a >> shamt;
            SRA:  res.result = $unsigned($signed(a) >>> shamt);
            // Signed less-than from the subtractor: sign of difference
            // corrected by signed overflow.
            SLT:  res.result = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ add_ovf};
            SEQ:  res.result = {{(DATA_W-1){1'b0}}, a == b};
            SRNE: res.result = {{(DATA_W-1){1'b0}}, a != b};
            default: res.result = '0;
        endcase
        res.zero = (res.result == '0);
    end

endmodule

// File: rtl/alu_64bit.sv
// Registered 64-bit ALU: combinational core followed by a single output
// register for result and flags; one new op accepted every cycle.
module alu_64bit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] operand_A,
    input  logic [DATA_W-1:0] operand_B,
    input  logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              overflow_flag
);

    alu_res_t res_nxt;
    alu_res_t res_q;

    alu_64bit_core u_core (
        .a   (operand_A),
        .b   (operand_B),
        .op  (alu_op),
        .res (res_nxt)
    );

    // Output register; async reset drops any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) res_q <= RES_RST;
        else        res_q <= res_nxt;
    end

    assign result        = res_q.result;
    assign zero_flag     = res_q.zero;
    assign carry_flag    = res_q.carry;
    assign overflow_flag = res_q.overflow;

endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed test-plan vectors plus random
// vectors checked through an expected-result queue.
module tb_alu_64bit;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        logic [63:0] r;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] operand_A;
    logic [63:0] operand_B;
    logic [3:0]  alu_op;
    logic [63:0] result;
    logic        zero_flag;
    logic        carry_flag;
    logic        overflow_flag;

    int n_vec;
    int n_mis;
    exp_t sb_q[$];

    alu_64bit dut (
        .clk           (clk),
        .reset         (reset),
        .operand_A     (operand_A),
        .operand_B     (operand_B),
        .alu_op        (alu_op),
        .result        (result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] r, input logic z,
                           input logic c, input logic v);
        chk({tag, ".res"}, result, r);
        chk({tag, ".zero"}, {63'd0, zero_flag}, {63'd0, z});
        chk({tag, ".carry"}, {63'd0, carry_flag}, {63'd0, c});
        chk({tag, ".ovf"}, {63'd0, overflow_flag}, {63'd0, v});
    endtask

    // Reference model, written independently of the RTL adder sharing.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        exp_t e;
        logic [64:0] w;
        logic [64:0] sx;
        e.tag = "rnd";
        e.r = '0; e.c = 1'b0; e.v = 1'b0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                sx = {a[63], a} + {b[63], b};
                e.r = w[63:0]; e.c = w[64]; e.v = sx[64] ^ sx[63];
            end
            4'd1: begin
                sx = {a[63], a} - {b[63], b};
                e.r = a - b; e.c = (a < b); e.v = sx[64] ^ sx[63];
            end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = a << b[5:0];
            4'd6: e.r = a >> b[5:0];
            4'd7: begin
                e.r = a;
                for (int i = 0; i < int'(b[5:0]); i++) e.r = {a[63], e.r[63:1]};
            end
            4'd8: e.r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9: e.r = (a == b) ? 64'd1 : 64'd0;
            4'd10: e.r = (a != b) ? 64'd1 : 64'd0;
            default: e.r = '0;
        endcase
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    // Drive one op at the falling edge, queue its expectation, then check
    // the oldest queued expectation just after the next rising edge.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input exp_t e);
        exp_t got;
        @(negedge clk);
        alu_op = op; operand_A = a; operand_B = b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            got = sb_q.pop_front();
            chk_out(got.tag, got.r, got.z, got.c, got.v);
        end
    endtask

    function automatic exp_t ex(input string tag, input logic [63:0] r, input logic z,
                                input logic c, input logic v);
        exp_t e;
        e.tag = tag; e.r = r; e.z = z; e.c = c; e.v = v;
        return e;
    endfunction

    initial begin
        logic [63:0] ra, rb;
        logic [3:0]  rop;
        n_vec = 0; n_mis = 0;
        reset = 1'b0;
        alu_op = ADD; operand_A = 64'd5; operand_B = 64'd7;

        // Reset held: outputs stay cleared while inputs and clock toggle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alu_op = 4'(i); operand_A = {$urandom, $urandom}; operand_B = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk_out("rst_hold", 64'd0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;

        issue(ADD, 64'd5, 64'd7, ex("add5_7", 64'hC, 1'b0, 1'b0, 1'b0));
        issue(ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ex("add_carry", 64'd0, 1'b1, 1'b1, 1'b0));
        issue(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              ex("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1));
        issue(SUB, 64'd3, 64'd5, ex("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0));
        issue(SUB, 64'h8000_0000_0000_0000, 64'd1,
              ex("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1));
        issue(SUB, 64'd9, 64'd9, ex("sub_eq", 64'd0, 1'b1, 1'b0, 1'b0));
        issue(SLL, 64'h8000_0000_0000_00F0, 64'h44, ex("sll", 64'h0000_0000_0000_0F00, 1'b0, 1'b0, 1'b0));
        issue(SRL, 64'h8000_0000_0000_00F0, 64'h44, ex("srl", 64'h0800_0000_0000_000F, 1'b0, 1'b0, 1'b0));
        issue(SRA, 64'h8000_0000_0000_00F0, 64'h44, ex("sra", 64'hF800_0000_0000_000F, 1'b0, 1'b0, 1'b0));
        issue(SRA, 64'h8000_0000_0000_00F0, 64'hFFC0, ex("sra0", 64'h8000_0000_0000_00F0, 1'b0, 1'b0, 1'b0));
        issue(SRL, 64'h8000_0000_0000_0000, 64'h3F, ex("srl63", 64'd1, 1'b0, 1'b0, 1'b0));
        issue(SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ex("slt_neg", 64'd1, 1'b0, 1'b0, 1'b0));
        issue(SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, ex("slt_pos", 64'd0, 1'b1, 1'b0, 1'b0));
        issue(SLT, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, ex("slt_ext", 64'd1, 1'b0, 1'b0, 1'b0));
        issue(SEQ, 64'h1234, 64'h1234, ex("seq", 64'd1, 1'b0, 1'b0, 1'b0));
        issue(SRNE, 64'h1234, 64'h1234, ex("srne", 64'd0, 1'b1, 1'b0, 1'b0));
        issue(4'b1111, 64'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, ex("rsvd", 64'd0, 1'b1, 1'b0, 1'b0));

        // Back-to-back: results must land on consecutive cycles.
        issue(ADD, 64'h10, 64'h20, ex("b2b_add", 64'h30, 1'b0, 1'b0, 1'b0));
        issue(AND, 64'hF0F0, 64'h0FF0, ex("b2b_and", 64'h00F0, 1'b0, 1'b0, 1'b0));
        issue(XOR, 64'hAAAA, 64'hAAAA, ex("b2b_xor", 64'd0, 1'b1, 1'b0, 1'b0));
        issue(OR, 64'h0F00, 64'h00F0, ex("b2b_or", 64'h0FF0, 1'b0, 1'b0, 1'b0));

        // Random ops against the reference model, reserved codes included.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = {$urandom, $urandom};
            rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
            issue(rop, ra, rb, model(rop, ra, rb));
        end

        // Mid-cycle reset clears outputs without a clock edge.
        issue(ADD, 64'd5, 64'd7, ex("pre_rst", 64'hC, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        alu_op = ADD; operand_A = 64'd1; operand_B = 64'd1;
        #2 reset = 1'b0;
        #1 chk_out("async_rst", 64'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk_out("rst_edge", 64'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk_out("post_rst", 64'd2, 1'b0, 1'b0, 1'b0);

        if (sb_q.size() != 0) chk("sb_left", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
